mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port (fetch/data) memory arbiter.
package mem_arb_pkg;

  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_gnt_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory request/response signals of the arbiter.
// The slave modport is the arbiter; master is the requesters plus memory.
interface mem_arbiter_if;

  logic        i_ready;
  logic [31:0] i_addr;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_ready;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_ready, i_addr,
    input  d_ready, d_addr, d_wdata, d_wstrb,
    input  mem_valid, mem_rdata,
    output i_valid, i_rdata, i_err,
    output d_valid, d_rdata, d_err,
    output mem_ready, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output i_ready, i_addr,
    output d_ready, d_addr, d_wdata, d_wstrb,
    output mem_valid, mem_rdata,
    input  i_valid, i_rdata, i_err,
    input  d_valid, d_rdata, d_err,
    input  mem_ready, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data requesters.
// Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a requester; grants one and issues mem_ready
// BUSY  | memory access outstanding, latched request held stable
// RESP  | one-cycle x_valid pulse to the granted port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]  state;
  arb_gnt_e    gnt;
  arb_gnt_e    last_gnt;

  logic        mem_ready_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wstrb_q;
  logic        i_valid_q;
  logic        d_valid_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

  logic        i_req;
  logic        d_req;
  logic        pick_d;
  logic        tmo_hit;

  assign i_req  = bus.i_ready & ~i_valid_q;
  assign d_req  = bus.d_ready & ~d_valid_q;
  assign pick_d = d_req & (~i_req | (last_gnt == GNT_I));

  // A stray mem_valid in IDLE also defers the grant, so mem_ready never
  // follows a mem_valid cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      gnt         <= GNT_I;
      last_gnt    <= GNT_D;
      mem_ready_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if ((i_req | d_req) & ~bus.mem_valid) begin
            state       <= ST_BUSY;
            mem_ready_q <= 1'b1;
            if (pick_d) begin
              gnt         <= GNT_D;
              mem_addr_q  <= bus.d_addr;
              mem_wdata_q <= bus.d_wdata;
              mem_wstrb_q <= bus.d_wstrb;
            end else begin
              gnt         <= GNT_I;
              mem_addr_q  <= bus.i_addr;
              mem_wdata_q <= '0;
              mem_wstrb_q <= '0;
            end
          end
        end
        ST_BUSY: begin
          if (bus.mem_valid | tmo_hit) begin
            state       <= ST_RESP;
            mem_ready_q <= 1'b0;
            last_gnt    <= gnt;
            if (gnt == GNT_D) begin
              d_valid_q <= 1'b1;
              d_rdata_q <= bus.mem_valid ? bus.mem_rdata : '0;
            end else begin
              i_valid_q <= 1'b1;
              i_rdata_q <= bus.mem_valid ? bus.mem_rdata : '0;
            end
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state       <= ST_IDLE;
          mem_ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             i_err_q;
  logic             d_err_q;

  // Fires on the TIMEOUT-th BUSY cycle; a same-cycle mem_valid wins.
  assign tmo_hit = (state == ST_BUSY) & ~bus.mem_valid & (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      if (state == ST_BUSY) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
      if ((state == ST_BUSY) & (bus.mem_valid | tmo_hit)) begin
        i_err_q <= tmo_hit & (gnt == GNT_I);
        d_err_q <= tmo_hit & (gnt == GNT_D);
      end
    end
  end

  assign bus.i_err = i_err_q;
  assign bus.d_err = d_err_q;
`else
  assign tmo_hit   = 1'b0;
  assign bus.i_err = 1'b0;
  assign bus.d_err = 1'b0;
`endif

  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.i_valid   = i_valid_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a single-cycle word memory model.
// Define MEM_ARB_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_mem_arbiter;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_run  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory: 64 words, reloaded on reset; addresses >= 0x100 never answer.
  logic [31:0] mem [0:63];
  logic        mv_r;
  logic        mv_inj;
  logic [31:0] rd_r;

  assign bus.mem_valid = mv_r | mv_inj;
  assign bus.mem_rdata = rd_r;

  always @(posedge clk) begin
    if (reset) begin
      mv_r <= 1'b0;
      rd_r <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= {16'hC0DE, 16'(i)};
      mem[4] <= 32'hDEADBEEF;
      mem[8] <= 32'hAABBCCDD;
      mem[9] <= 32'h55667788;
    end else begin
      mv_r <= 1'b0;
      if (bus.mem_ready && !mv_r && bus.mem_addr < 32'h100) begin
        mv_r <= 1'b1;
        rd_r <= mem[bus.mem_addr[7:2]];
        for (int b = 0; b < 4; b++)
          if (bus.mem_wstrb[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end

  exp_t        sb[$];
  exp_t        e_pop;
  logic        got_d;
  logic [31:0] got_rd;
  logic        got_err;
  logic        prev_mv = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.i_valid || bus.d_valid) begin
        n_run++;
        got_d   = bus.d_valid;
        got_rd  = got_d ? bus.d_rdata : bus.i_rdata;
        got_err = got_d ? bus.d_err : bus.i_err;
        if (bus.i_valid && bus.d_valid) begin
          n_fail++;
          $display("FAIL both_valid: i_valid=%b d_valid=%b, required one at most", bus.i_valid, bus.d_valid);
        end else if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_resp at cycle %0d: is_d=%b rdata=%h, required no response", cyc, got_d, got_rd);
        end else begin
          e_pop = sb.pop_front();
          if ({got_d, got_rd, got_err} !== {e_pop.is_d, e_pop.rdata, e_pop.err}) begin
            n_fail++;
            $display("FAIL resp: got is_d=%b rdata=%h err=%b, required is_d=%b rdata=%h err=%b",
                     got_d, got_rd, got_err, e_pop.is_d, e_pop.rdata, e_pop.err);
          end
        end
      end
      if (prev_mv) begin
        n_run++;
        if (bus.mem_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ready_after_valid: mem_ready=%b, required 0", bus.mem_ready);
        end
      end
    end
    prev_mv = bus.mem_valid;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    mv_inj      = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_addr  = '0;
    bus.d_ready = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_wstrb = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_run++;
    if ({bus.mem_ready, bus.i_valid, bus.d_valid, bus.i_err, bus.d_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 00000",
               {bus.mem_ready, bus.i_valid, bus.d_valid, bus.i_err, bus.d_err});
    end
    n_run++;
    if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h, required 0", bus.mem_addr, bus.mem_wdata);
    end
    n_run++;
    if (bus.mem_wstrb !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_wstrb: got %h, required 0", bus.mem_wstrb);
    end
    n_run++;
    if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got i=%h d=%h, required 0", bus.i_rdata, bus.d_rdata);
    end
  endtask

  task automatic test_fetch();
    bus.i_ready = 1'b1;
    bus.i_addr  = 32'h10;
    sb.push_back('{is_d: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
    tick();
    n_run++;
    if ({bus.mem_ready, bus.mem_wstrb, bus.mem_addr} !== {1'b1, 4'h0, 32'h10}) begin
      n_fail++;
      $display("FAIL fetch_issue: got ready=%b wstrb=%h addr=%h, required 1 0 00000010",
               bus.mem_ready, bus.mem_wstrb, bus.mem_addr);
    end
    tick();
    n_run++;
    if ({bus.mem_ready, bus.i_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL fetch_busy: got ready=%b i_valid=%b, required 1 0", bus.mem_ready, bus.i_valid);
    end
    tick();
    n_run++;
    if ({bus.i_valid, bus.d_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL fetch_latency: got i_valid=%b d_valid=%b, required 1 0", bus.i_valid, bus.d_valid);
    end
    bus.i_ready = 1'b0;
    tick();
    n_run++;
    if ({bus.i_valid, bus.mem_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL fetch_pulse: got i_valid=%b mem_ready=%b, required 0 0", bus.i_valid, bus.mem_ready);
    end
  endtask

  task automatic test_write();
    bus.d_ready = 1'b1;
    bus.d_addr  = 32'h20;
    bus.d_wdata = 32'h11223344;
    bus.d_wstrb = 4'b0011;
    sb.push_back('{is_d: 1'b1, rdata: 32'hAABBCCDD, err: 1'b0});
    tick();
    n_run++;
    if ({bus.mem_wstrb, bus.mem_wdata, bus.mem_addr} !== {4'b0011, 32'h11223344, 32'h20}) begin
      n_fail++;
      $display("FAIL write_issue: got wstrb=%b wdata=%h addr=%h, required 0011 11223344 00000020",
               bus.mem_wstrb, bus.mem_wdata, bus.mem_addr);
    end
    repeat (2) tick();
    n_run++;
    if (bus.d_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL write_latency: got d_valid=%b, required 1", bus.d_valid);
    end
    bus.d_ready = 1'b0;
    tick();
    bus.d_ready = 1'b1;
    bus.d_wstrb = 4'b0000;
    sb.push_back('{is_d: 1'b1, rdata: 32'hAABB3344, err: 1'b0});
    tick();
    n_run++;
    if (bus.mem_wstrb !== 4'b0000) begin
      n_fail++;
      $display("FAIL read_wstrb: got %b, required 0000", bus.mem_wstrb);
    end
    repeat (2) tick();
    n_run++;
    if (bus.d_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL read_latency: got d_valid=%b, required 1", bus.d_valid);
    end
    bus.d_ready = 1'b0;
    tick();
  endtask

  task automatic test_tie();
    int done_i;
    int done_d;
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_addr  = 32'h10;
    bus.d_ready = 1'b1;
    bus.d_addr  = 32'h24;
    bus.d_wstrb = 4'b0000;
    sb.push_back('{is_d: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
    sb.push_back('{is_d: 1'b1, rdata: 32'h55667788, err: 1'b0});
    tick();
    n_run++;
    if (bus.mem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL tie_first: got mem_addr=%h, required 00000010", bus.mem_addr);
    end
    repeat (2) tick();
    n_run++;
    if ({bus.i_valid, bus.d_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL tie_i_valid: got i=%b d=%b, required 1 0", bus.i_valid, bus.d_valid);
    end
    bus.i_ready = 1'b0;
    repeat (2) tick();
    n_run++;
    if ({bus.mem_ready, bus.mem_addr} !== {1'b1, 32'h24}) begin
      n_fail++;
      $display("FAIL tie_second: got ready=%b addr=%h, required 1 00000024", bus.mem_ready, bus.mem_addr);
    end
    repeat (2) tick();
    n_run++;
    if ({bus.i_valid, bus.d_valid} !== 2'b01) begin
      n_fail++;
      $display("FAIL tie_d_valid: got i=%b d=%b, required 0 1", bus.i_valid, bus.d_valid);
    end
    bus.d_ready = 1'b0;
    tick();
    bus.i_ready = 1'b1;
    bus.i_addr  = 32'h14;
    bus.d_ready = 1'b1;
    bus.d_addr  = 32'h28;
    sb.push_back('{is_d: 1'b0, rdata: 32'hC0DE0005, err: 1'b0});
    sb.push_back('{is_d: 1'b1, rdata: 32'hC0DE000A, err: 1'b0});
    tick();
    n_run++;
    if (bus.mem_addr !== 32'h14) begin
      n_fail++;
      $display("FAIL tie_rr_next: got mem_addr=%h, required 00000014", bus.mem_addr);
    end
    done_i = 0;
    done_d = 0;
    for (int t = 0; t < 20 && !(done_i && done_d); t++) begin
      tick();
      if (bus.i_valid) begin bus.i_ready = 1'b0; done_i = 1; end
      if (bus.d_valid) begin bus.d_ready = 1'b0; done_d = 1; end
    end
    n_run++;
    if (!(done_i && done_d)) begin
      n_fail++;
      $display("FAIL tie_rr_timeout: got done_i=%0d done_d=%0d, required 1 1", done_i, done_d);
      bus.i_ready = 1'b0;
      bus.d_ready = 1'b0;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int got;
    int last;
    got  = 0;
    last = -1;
    bus.i_ready = 1'b1;
    bus.i_addr  = 32'h40;
    sb.push_back('{is_d: 1'b0, rdata: 32'hC0DE0010, err: 1'b0});
    for (int t = 0; t < 40 && got < 3; t++) begin
      tick();
      if (bus.i_valid) begin
        got++;
        if (last >= 0) begin
          n_run++;
          if (cyc - last !== 4) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d cycles, required 4", cyc - last);
          end
        end
        last = cyc;
        if (got < 3) begin
          bus.i_addr = 32'h40 + 32'(4 * got);
          sb.push_back('{is_d: 1'b0, rdata: {16'hC0DE, 16'(16 + got)}, err: 1'b0});
        end else begin
          bus.i_ready = 1'b0;
        end
      end
    end
    n_run++;
    if (got !== 3) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d responses, required 3", got);
      bus.i_ready = 1'b0;
    end
    tick();
  endtask

  task automatic test_drop_ready();
    bus.d_ready = 1'b1;
    bus.d_addr  = 32'h30;
    bus.d_wstrb = 4'b0000;
    sb.push_back('{is_d: 1'b1, rdata: 32'hC0DE000C, err: 1'b0});
    tick();
    bus.d_ready = 1'b0;
    repeat (2) tick();
    n_run++;
    if (bus.d_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_ready: got d_valid=%b, required 1", bus.d_valid);
    end
    tick();
  endtask

  task automatic test_ignore_mv();
    logic bad;
    bad    = 1'b0;
    mv_inj = 1'b1;
    tick();
    mv_inj = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      if ({bus.mem_ready, bus.i_valid, bus.d_valid} !== 3'b000) bad = 1'b1;
    end
    n_run++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_mem_valid: got activity=%b, required 0", bad);
    end
  endtask

  task automatic test_reset_busy();
    logic bad;
    bus.d_ready = 1'b1;
    bus.d_addr  = 32'h0002_0000;
    bus.d_wstrb = 4'b0000;
    tick();
    n_run++;
    if (bus.mem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy_issue: got mem_ready=%b, required 1", bus.mem_ready);
    end
    repeat (2) tick();
    reset       = 1'b1;
    bus.d_ready = 1'b0;
    tick();
    reset = 1'b0;
    n_run++;
    if ({bus.mem_ready, bus.i_valid, bus.d_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_busy_abort: got ready=%b i=%b d=%b, required 0 0 0",
               bus.mem_ready, bus.i_valid, bus.d_valid);
    end
    tick();
    mv_inj = 1'b1;
    tick();
    mv_inj = 1'b0;
    bad    = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if ({bus.mem_ready, bus.i_valid, bus.d_valid} !== 3'b000) bad = 1'b1;
    end
    n_run++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy_late_valid: got activity=%b, required 0", bad);
    end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int hi_cnt;
    int seen;
    hi_cnt = 0;
    seen   = 0;
    bus.d_ready = 1'b1;
    bus.d_addr  = 32'h0002_0000;
    bus.d_wstrb = 4'b0000;
    sb.push_back('{is_d: 1'b1, rdata: 32'h0, err: 1'b1});
    for (int t = 0; t < 60 && !seen; t++) begin
      tick();
      if (bus.mem_ready) hi_cnt++;
      if (bus.d_valid) begin
        seen        = 1;
        bus.d_ready = 1'b0;
      end
    end
    n_run++;
    if ({seen, hi_cnt} !== {32'd1, 32'd16}) begin
      n_fail++;
      $display("FAIL timeout_len: got seen=%0d busy=%0d, required 1 16", seen, hi_cnt);
      bus.d_ready = 1'b0;
    end
    tick();
  endtask
`else
  task automatic test_hang();
    logic dropped;
    dropped     = 1'b0;
    bus.d_ready = 1'b1;
    bus.d_addr  = 32'h0002_0000;
    bus.d_wstrb = 4'b0000;
    tick();
    for (int t = 0; t < 40; t++) begin
      if (bus.mem_ready !== 1'b1) dropped = 1'b1;
      tick();
    end
    n_run++;
    if (dropped !== 1'b0) begin
      n_fail++;
      $display("FAIL hang_wait: got mem_ready dropped=%b, required 0", dropped);
    end
    reset       = 1'b1;
    bus.d_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask
`endif

  task automatic test_drain();
    n_run++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending responses, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_tie();
    test_back_to_back();
    test_drop_ready();
    test_ignore_mv();
    test_reset_busy();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hang();
`endif
    repeat (2) tick();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
